// File: rtl/cpu_pkg.sv
// Types and constants shared by the instruction fetch front end.
package cpu_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    FETCH_OP,
    FETCH_A,
    FETCH_B,
    LOAD,
    WAIT_EXEC,
    HALTED
  } fetch_state_t;

  localparam int OPCODE_LEN_MSB = 7;
  localparam int OPCODE_LEN_LSB = 6;

  // Number of operand bytes that follow an opcode; both upper encodings mean two.
  function automatic logic [1:0] operand_count(input byte_t op);
    logic [1:0] len;
    len = op[OPCODE_LEN_MSB:OPCODE_LEN_LSB];
    case (len)
      2'b00:   operand_count = 2'd0;
      2'b01:   operand_count = 2'd1;
      default: operand_count = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: branch load has priority over sequential increment.
module program_counter #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_val,
  output logic [ADDR_WIDTH-1:0] pc
);

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] pc_d;
  logic [ADDR_WIDTH-1:0] pc_q;

  // Natural overflow of the adder gives the modulo wrap at the top of memory.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch FSM: reads opcode and operand bytes, strobes the IR, waits for execute.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  byte_t                 mem_data,
  input  logic                  mem_valid,
  output byte_t                 opcode,
  output byte_t                 operando1,
  output byte_t                 operando2,
  output logic                  IR_load,
  input  logic                  exec_done,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted
);

  fetch_state_t state_d, state_q;
  logic         mem_rd_d, mem_rd_q;
  logic         ir_load_d, ir_load_q;
  logic         halted_d, halted_q;
  byte_t        opcode_d, opcode_q;
  byte_t        op1_d, op1_q;
  byte_t        op2_d, op2_q;
  logic         pc_inc;
  logic         pc_ld;
  logic         rd_done;
  logic [ADDR_WIDTH-1:0] pc_cur;

  program_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (pc_inc),
    .load     (pc_ld),
    .load_val (pc_in),
    .pc       (pc_cur)
  );

  // A byte only counts when a read is actually outstanding.
  assign rd_done = mem_rd_q & mem_valid;

  always_comb begin
    state_d   = state_q;
    mem_rd_d  = mem_rd_q;
    ir_load_d = 1'b0;
    halted_d  = halted_q;
    opcode_d  = opcode_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    pc_inc    = 1'b0;
    pc_ld     = 1'b0;

    case (state_q)
      FETCH_OP: begin
        // mem_rd_q low marks the entry cycle, the only point halt is honoured.
        if (!mem_rd_q) begin
          if (halt) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else begin
            mem_rd_d = 1'b1;
          end
        end else if (rd_done) begin
          opcode_d = mem_data;
          op1_d    = '0;
          op2_d    = '0;
          pc_inc   = 1'b1;
          if (operand_count(mem_data) != 2'd0) begin
            state_d = FETCH_A;
          end else begin
            state_d   = LOAD;
            mem_rd_d  = 1'b0;
            ir_load_d = 1'b1;
          end
        end
      end

      FETCH_A: begin
        if (rd_done) begin
          op1_d  = mem_data;
          pc_inc = 1'b1;
          if (operand_count(opcode_q) == 2'd2) begin
            state_d = FETCH_B;
          end else begin
            state_d   = LOAD;
            mem_rd_d  = 1'b0;
            ir_load_d = 1'b1;
          end
        end
      end

      FETCH_B: begin
        if (rd_done) begin
          op2_d     = mem_data;
          pc_inc    = 1'b1;
          state_d   = LOAD;
          mem_rd_d  = 1'b0;
          ir_load_d = 1'b1;
        end
      end

      LOAD: begin
        state_d = WAIT_EXEC;
      end

      WAIT_EXEC: begin
        if (exec_done) begin
          pc_ld   = pc_load;
          state_d = FETCH_OP;
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d  = FETCH_OP;
        mem_rd_d = 1'b0;
        halted_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH_OP;
      mem_rd_q  <= 1'b0;
      ir_load_q <= 1'b0;
      halted_q  <= 1'b0;
      opcode_q  <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
    end else begin
      state_q   <= state_d;
      mem_rd_q  <= mem_rd_d;
      ir_load_q <= ir_load_d;
      halted_q  <= halted_d;
      opcode_q  <= opcode_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
    end
  end

  assign mem_addr  = pc_cur;
  assign pc        = pc_cur;
  assign mem_rd    = mem_rd_q;
  assign IR_load   = ir_load_q;
  assign halted    = halted_q;
  assign opcode    = opcode_q;
  assign operando1 = op1_q;
  assign operando2 = op2_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: one instance at the default reset PC, one at 0x10.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Main instance (RESET_PC = 0) with a wait-state memory model.
  logic [7:0] mem_addr, mem_data, opcode, operando1, operando2, pc_in, pc;
  logic       mem_rd, mem_valid, IR_load, exec_done, pc_load, halt, halted;
  logic [7:0] mem [256];
  int         lat = 0;
  int         wcnt = 0;
  int         ir_cnt = 0;

  fetch_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_valid (mem_valid),
    .opcode    (opcode),
    .operando1 (operando1),
    .operando2 (operando2),
    .IR_load   (IR_load),
    .exec_done (exec_done),
    .pc_load   (pc_load),
    .pc_in     (pc_in),
    .halt      (halt),
    .pc        (pc),
    .halted    (halted)
  );

  assign mem_data  = mem[mem_addr];
  assign mem_valid = mem_rd && (wcnt >= lat);

  always @(posedge clk) begin
    if (mem_rd && !mem_valid) wcnt <= wcnt + 1;
    else                      wcnt <= 0;
  end

  always @(negedge clk) begin
    if (IR_load) ir_cnt <= ir_cnt + 1;
  end

  // Second instance (RESET_PC = 0x10), zero-wait memory of zeros, exec_done held high.
  logic [7:0] mem_addr_a, opcode_a, operando1_a, operando2_a, pc_a;
  logic       mem_rd_a, IR_load_a, halted_a;
  logic [7:0] mem_a [256];

  fetch_sequencer #(.ADDR_WIDTH(8), .RESET_PC(8'h10)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_addr  (mem_addr_a),
    .mem_rd    (mem_rd_a),
    .mem_data  (mem_a[mem_addr_a]),
    .mem_valid (mem_rd_a),
    .opcode    (opcode_a),
    .operando1 (operando1_a),
    .operando2 (operando2_a),
    .IR_load   (IR_load_a),
    .exec_done (1'b1),
    .pc_load   (1'b0),
    .pc_in     (8'h00),
    .halt      (1'b0),
    .pc        (pc_a),
    .halted    (halted_a)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int  ir_snap;
    logic rd_seen;

    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'h00;
      mem_a[i] = 8'h00;
    end
    mem[8'h00] = 8'h85;
    mem[8'h01] = 8'h12;
    mem[8'h02] = 8'h34;
    mem[8'h03] = 8'h40;
    mem[8'h04] = 8'hAA;
    mem[8'h80] = 8'h00;
    mem[8'hFF] = 8'h80;

    rst_n = 1'b0; exec_done = 1'b0; pc_load = 1'b0; pc_in = 8'h00; halt = 1'b0;
    step(2);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_ir_load", {31'd0, IR_load}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'h00);
    chk("rst_a_mem_addr", {24'd0, mem_addr_a}, 32'h10);

    rst_n = 1'b1;
    step(1);
    chk("first_rd", {31'd0, mem_rd}, 32'd1);
    chk("first_addr", {24'd0, mem_addr}, 32'h00);
    step(1);
    chk("a_ir_load", {31'd0, IR_load_a}, 32'd1);
    chk("a_ir_bytes", {8'd0, opcode_a, operando1_a, operando2_a}, 32'h000000);
    chk("two_op_early", {31'd0, IR_load}, 32'd0);
    step(1);
    chk("two_op_early2", {31'd0, IR_load}, 32'd0);
    step(1);
    chk("two_op_ir_load", {31'd0, IR_load}, 32'd1);
    chk("two_op_bytes", {8'd0, opcode, operando1, operando2}, 32'h851234);
    chk("two_op_pc", {24'd0, pc}, 32'h03);
    chk("a_pc_next", {24'd0, pc_a}, 32'h11);
    chk("a_fetch_entry_rd", {31'd0, mem_rd_a}, 32'd0);
    step(1);
    chk("two_op_pulse_end", {31'd0, IR_load}, 32'd0);
    chk("two_op_hold", {8'd0, opcode, operando1, operando2}, 32'h851234);

    // One operand with three wait states per byte.
    lat = 3; exec_done = 1'b1;
    step(1);
    exec_done = 1'b0;
    chk("one_op_entry_pc", {24'd0, mem_addr}, 32'h03);
    chk("one_op_entry_rd", {31'd0, mem_rd}, 32'd0);
    step(1);
    chk("one_op_rd", {31'd0, mem_rd}, 32'd1);
    chk("one_op_wait_valid", {31'd0, mem_valid}, 32'd0);
    step(3);
    chk("one_op_addr_held", {24'd0, mem_addr}, 32'h03);
    chk("one_op_valid", {31'd0, mem_valid}, 32'd1);
    step(1);
    chk("one_op_opcode", {24'd0, opcode}, 32'h40);
    chk("one_op_cleared", {16'd0, operando1, operando2}, 32'h0000);
    chk("one_op_next_addr", {24'd0, mem_addr}, 32'h04);
    step(3);
    chk("one_op_a_addr_held", {24'd0, mem_addr}, 32'h04);
    chk("one_op_a_no_ir", {31'd0, IR_load}, 32'd0);
    step(1);
    chk("one_op_ir_load", {31'd0, IR_load}, 32'd1);
    chk("one_op_bytes", {8'd0, opcode, operando1, operando2}, 32'h40AA00);
    chk("one_op_pc", {24'd0, pc}, 32'h05);
    step(1);
    chk("ir_pulse_count", ir_cnt, 32'd2);

    // pc_load alone is ignored; with exec_done it branches.
    pc_load = 1'b1; pc_in = 8'h80;
    step(2);
    chk("pc_load_alone", {24'd0, pc}, 32'h05);
    chk("pc_load_alone_rd", {31'd0, mem_rd}, 32'd0);
    exec_done = 1'b1;
    step(1);
    chk("branch_addr", {24'd0, mem_addr}, 32'h80);
    exec_done = 1'b0; pc_load = 1'b0; lat = 0;
    step(3);
    chk("branch_opcode", {24'd0, opcode}, 32'h00);
    chk("branch_pc", {24'd0, pc}, 32'h81);

    // Branch to 0xFF; the two-operand instruction wraps through 0x00 and 0x01.
    pc_load = 1'b1; pc_in = 8'hFF; exec_done = 1'b1;
    step(1);
    chk("wrap_start_pc", {24'd0, pc}, 32'hFF);
    pc_load = 1'b0; exec_done = 1'b0;
    step(2);
    chk("wrap_addr_a", {24'd0, mem_addr}, 32'h00);
    step(1);
    chk("wrap_addr_b", {24'd0, mem_addr}, 32'h01);
    step(1);
    chk("wrap_ir_load", {31'd0, IR_load}, 32'd1);
    chk("wrap_bytes", {8'd0, opcode, operando1, operando2}, 32'h808512);
    chk("wrap_pc", {24'd0, pc}, 32'h02);
    step(1);

    // Halt at the next instruction boundary.
    halt = 1'b1; exec_done = 1'b1;
    step(1);
    exec_done = 1'b0;
    chk("halt_entry_halted", {31'd0, halted}, 32'd0);
    step(1);
    chk("halted", {31'd0, halted}, 32'd1);
    halt = 1'b0;
    rd_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (mem_rd) rd_seen = 1'b1;
    end
    chk("halted_no_rd", {31'd0, rd_seen}, 32'd0);
    chk("halted_sticky", {31'd0, halted}, 32'd1);
    chk("halted_pc", {24'd0, pc}, 32'h02);

    // New run, reset asserted while stalled in FETCH_A.
    rst_n = 1'b0;
    #1;
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);
    step(1);
    lat = 3;
    rst_n = 1'b1;
    ir_snap = ir_cnt;
    step(5);
    chk("abort_opcode", {24'd0, opcode}, 32'h85);
    chk("abort_in_fetch_a", {23'd0, mem_rd, mem_addr}, 32'h101);
    step(1);
    rst_n = 1'b0;
    #1;
    chk("abort_bytes", {8'd0, opcode, operando1, operando2}, 32'h000000);
    chk("abort_strobes", {29'd0, mem_rd, IR_load, halted}, 32'd0);
    chk("abort_pc", {16'd0, pc, mem_addr}, 32'h0000);
    step(3);
    chk("abort_no_ir_load", ir_cnt, ir_snap);
    chk("abort_held_rd", {31'd0, mem_rd}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
